// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS memory interface stage.
// Holds the access FSM states, instruction field positions and the word-alignment test.
package mips_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    localparam logic [1:0] ALIGN_OK = 2'b00;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == ALIGN_OK;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Saturating cycle counter that flags the TIMEOUT-th enabled cycle after a clear.
// Latency: expired is combinational in that cycle; no backpressure, TIMEOUT=0 never expires.
module bus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             CW    = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0]  LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // Fires during the cycle whose increment brings the count up to TIMEOUT.
    assign expired = (TIMEOUT != 0) && en && (count == LAST);

endmodule

// File: rtl/mem_bus_if.sv
// Turns controller memory strobes into one ready/valid transaction and owns IR/MDR.
// Latency: read 3 / write 2 stall cycles at zero wait; m_valid holds until m_ready or timeout.
module mem_bus_if
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              memwrite,
    input  logic              irwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        op,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] mdr,
    output logic              bus_err,
    output logic              m_valid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    state_t state;
    logic   req_ir;
    logic   expired;

    bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == S_IDLE),
        .en      (state == S_REQ || state == S_WAIT),
        .expired (expired)
    );

    // The request registers double as the bus outputs, so m_* stay stable for the whole REQ phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            instr   <= '0;
            mdr     <= '0;
            bus_err <= 1'b0;
            m_valid <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            req_ir  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        m_addr  <= addr;
                        m_wdata <= wdata;
                        m_we    <= memwrite;
                        req_ir  <= irwrite;
                        if (is_aligned(addr[1:0])) begin
                            m_valid <= 1'b1;
                            state   <= S_REQ;
                        end else begin
                            state   <= S_ERR;
                        end
                    end
                end
                S_REQ: begin
                    if (expired) begin
                        m_valid <= 1'b0;
                        state   <= S_ERR;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= m_we ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (expired) begin
                        state <= S_ERR;
                    end else if (m_rvalid) begin
                        if (req_ir) begin
                            instr <= m_rdata;
                        end else begin
                            mdr   <= m_rdata;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_ERR: begin
                    bus_err <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall = (state == S_IDLE && mem_req) || state == S_REQ || state == S_WAIT;
    assign op    = instr[OP_MSB:OP_LSB];
    assign funct = instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: fetch, waited load, store, misalign, timeout and mid-access reset.
module tb_mem_bus_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, t_mem_req;
    logic        memwrite, irwrite;
    logic [31:0] addr, wdata;
    logic        m_ready, m_rvalid;
    logic [31:0] m_rdata;

    logic        stall, bus_err, m_valid, m_we;
    logic [31:0] instr, mdr, m_addr, m_wdata;
    logic [5:0]  op, funct;

    logic        t_stall, t_bus_err, t_m_valid, t_m_we;
    logic [31:0] t_instr, t_mdr, t_m_addr, t_m_wdata;
    logic [5:0]  t_op, t_funct;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_if dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .memwrite(memwrite),
        .irwrite(irwrite), .addr(addr), .wdata(wdata), .stall(stall),
        .instr(instr), .op(op), .funct(funct), .mdr(mdr), .bus_err(bus_err),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    mem_bus_if #(.TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .mem_req(t_mem_req), .memwrite(memwrite),
        .irwrite(irwrite), .addr(addr), .wdata(wdata), .stall(t_stall),
        .instr(t_instr), .op(t_op), .funct(t_funct), .mdr(t_mdr), .bus_err(t_bus_err),
        .m_valid(t_m_valid), .m_we(t_m_we), .m_addr(t_m_addr), .m_wdata(t_m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one access on dut and plays a memory that accepts after rdy_dly
    // valid cycles and answers reads rv_dly cycles later than the earliest legal slot.
    task automatic access(input logic we, input logic irw, input logic [31:0] a,
                          input logic [31:0] wd, input int rdy_dly, input int rv_dly,
                          input logic [31:0] rd, output int stalls, output logic saw_valid);
        int   vcnt = 0;
        int   wcnt = 0;
        logic acc = 1'b0;
        logic got = 1'b0;
        logic fin = 1'b0;
        logic v_pre;
        mem_req = 1'b1; memwrite = we; irwrite = irw; addr = a; wdata = wd;
        stalls = 0; saw_valid = 1'b0;
        for (int c = 0; c < 64 && !fin; c++) begin
            m_ready  = m_valid && (vcnt >= rdy_dly);
            m_rvalid = acc && !got && !we && (wcnt >= rv_dly);
            m_rdata  = m_rvalid ? rd : 32'h5555_5555;
            @(negedge clk);
            v_pre = m_valid;
            if (m_valid) begin
                saw_valid = 1'b1;
                chk("req_addr_held", m_addr, a);
                chk("req_we_held", {31'b0, m_we}, {31'b0, we});
                if (we) chk("req_wdata_held", m_wdata, wd);
            end
            if (stall) stalls++;
            else       fin = 1'b1;
            @(posedge clk); #1;
            if (m_rvalid) got = 1'b1;
            if (acc) wcnt++;
            if (m_ready) begin
                acc  = 1'b1;
                wcnt = 0;
            end else if (v_pre) begin
                vcnt++;
            end
        end
        chk("access_completed_in_bound", {31'b0, fin}, 32'd1);
        mem_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    initial begin
        int   stalls, n;
        logic sv, fin, mv_at_err;

        reset = 1'b0; mem_req = 1'b0; t_mem_req = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
        addr = '0; wdata = '0; m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_we", {31'b0, m_we}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_mdr", mdr, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Zero-wait instruction fetch: add $t0,$t0,$t1
        access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 0, 0, 32'h0109_4020, stalls, sv);
        chk("fetch_stalls", stalls, 32'd3);
        chk("fetch_instr", instr, 32'h0109_4020);
        chk("fetch_op", {26'b0, op}, 32'h00);
        chk("fetch_funct", {26'b0, funct}, 32'h20);
        chk("fetch_mdr_unchanged", mdr, 32'd0);

        // Load with 2 ready-delay and 3 rvalid-delay cycles
        access(1'b0, 1'b0, 32'h0000_0200, 32'h0, 2, 3, 32'hCAFE_0001, stalls, sv);
        chk("load_stalls", stalls, 32'd8);
        chk("load_mdr", mdr, 32'hCAFE_0001);
        chk("load_instr_unchanged", instr, 32'h0109_4020);

        // Store held on the bus through 2 not-ready cycles
        access(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2, 0, 32'h0, stalls, sv);
        chk("store_stalls", stalls, 32'd4);
        chk("store_saw_valid", {31'b0, sv}, 32'd1);
        chk("store_instr_unchanged", instr, 32'h0109_4020);
        chk("store_mdr_unchanged", mdr, 32'hCAFE_0001);
        chk("store_no_err", {31'b0, bus_err}, 32'd0);

        // Misaligned read: straight to ERR, nothing on the bus
        access(1'b0, 1'b0, 32'h0000_0102, 32'h0, 0, 0, 32'h0, stalls, sv);
        chk("misalign_stalls", stalls, 32'd1);
        chk("misalign_no_valid", {31'b0, sv}, 32'd0);
        chk("misalign_bus_err", {31'b0, bus_err}, 32'd1);
        chk("misalign_mdr_unchanged", mdr, 32'hCAFE_0001);
        @(posedge clk); #1;
        chk("bus_err_sticky", {31'b0, bus_err}, 32'd1);

        // Timeout on the TIMEOUT=4 instance: memory never accepts
        irwrite = 1'b1; memwrite = 1'b0; addr = 32'h0000_0080; m_ready = 1'b0;
        t_mem_req = 1'b1; n = 0; fin = 1'b0; mv_at_err = 1'b1;
        for (int c = 0; c < 20 && !fin; c++) begin
            @(negedge clk);
            if (t_stall) n++;
            else begin
                fin = 1'b1;
                mv_at_err = t_m_valid;
            end
            @(posedge clk); #1;
        end
        t_mem_req = 1'b0;
        chk("timeout_reached_err", {31'b0, fin}, 32'd1);
        chk("timeout_stalls", n, 32'd5);
        chk("timeout_valid_dropped", {31'b0, mv_at_err}, 32'd0);
        chk("timeout_bus_err", {31'b0, t_bus_err}, 32'd1);
        m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        chk("late_rvalid_instr", t_instr, 32'd0);
        chk("late_rvalid_mdr", t_mdr, 32'd0);

        // Reset while waiting for read data, then a clean fetch
        mem_req = 1'b1; irwrite = 1'b1; memwrite = 1'b0; addr = 32'h0000_0044; m_ready = 1'b0;
        @(posedge clk); #1;
        chk("rstw_req_valid", {31'b0, m_valid}, 32'd1);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("rstw_in_wait_stall", {31'b0, stall}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rstw_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rstw_instr", instr, 32'd0);
        chk("rstw_mdr", mdr, 32'd0);
        chk("rstw_bus_err", {31'b0, bus_err}, 32'd0);
        chk("rstw_m_addr", m_addr, 32'd0);
        chk("rstw_idle_stall", {31'b0, stall}, 32'd1);
        mem_req = 1'b0;
        #1;
        chk("rstw_idle_no_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'h0000_0048, 32'h0, 0, 0, 32'h8C48_0004, stalls, sv);
        chk("post_rst_stalls", stalls, 32'd3);
        chk("post_rst_instr", instr, 32'h8C48_0004);
        chk("post_rst_op", {26'b0, op}, 32'h23);
        chk("post_rst_funct", {26'b0, funct}, 32'h04);
        chk("post_rst_bus_err", {31'b0, bus_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
